// File: rtl/ex_stage_pkg.sv
// Shared execute-stage definitions: ALU op codes, widths, FSM states
// and single-step / barrel shift helpers.
package ex_stage_pkg;

  localparam int DATA_W     = 32;
  localparam int SHAMT_W    = 5;
  localparam int ALU_OP_W   = 8;
  localparam int REG_ADDR_W = 5;

  localparam logic [ALU_OP_W-1:0] EXE_NOP_OP = 8'b0000_0000;
  localparam logic [ALU_OP_W-1:0] EXE_AND_OP = 8'b0010_0100;
  localparam logic [ALU_OP_W-1:0] EXE_OR_OP  = 8'b0010_0101;
  localparam logic [ALU_OP_W-1:0] EXE_XOR_OP = 8'b0010_0110;
  localparam logic [ALU_OP_W-1:0] EXE_NOR_OP = 8'b0010_0111;
  localparam logic [ALU_OP_W-1:0] EXE_SLL_OP = 8'b0111_1100;
  localparam logic [ALU_OP_W-1:0] EXE_SRL_OP = 8'b0000_0010;
  localparam logic [ALU_OP_W-1:0] EXE_SRA_OP = 8'b0000_0011;

  localparam logic [DATA_W-1:0] ZERO_WORD = '0;

  typedef enum logic {
    EX_IDLE,
    EX_SHIFT
  } ex_state_e;

  function automatic logic is_shift(input logic [ALU_OP_W-1:0] op);
    return (op == EXE_SLL_OP) || (op == EXE_SRL_OP) || (op == EXE_SRA_OP);
  endfunction

  // SRA keeps re-injecting the current MSB, so the sign stays sticky
  function automatic logic [DATA_W-1:0] shift1(
    input logic [ALU_OP_W-1:0] op,
    input logic [DATA_W-1:0]   d
  );
    logic [DATA_W-1:0] r;
    r = d;
    case (op)
      EXE_SLL_OP: r = {d[DATA_W-2:0], 1'b0};
      EXE_SRL_OP: r = {1'b0, d[DATA_W-1:1]};
      EXE_SRA_OP: r = {d[DATA_W-1], d[DATA_W-1:1]};
      default:    r = d;
    endcase
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] shiftn(
    input logic [ALU_OP_W-1:0] op,
    input logic [DATA_W-1:0]   d,
    input logic [SHAMT_W-1:0]  n
  );
    logic [DATA_W-1:0] r;
    r = d;
    case (op)
      EXE_SLL_OP: r = d << n;
      EXE_SRL_OP: r = d >> n;
      EXE_SRA_OP: r = DATA_W'($signed(d) >>> n);
      default:    r = d;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ex_serial_shifter.sv
// Serial 1-bit/cycle shifter: holds the partial result, remaining
// count and the latched op/destination of the shift in flight.
module ex_serial_shifter
  import ex_stage_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  step,
  input  logic [ALU_OP_W-1:0]   op,
  input  logic [DATA_W-1:0]     data,
  input  logic [SHAMT_W-1:0]    amt,
  input  logic                  wreg,
  input  logic [REG_ADDR_W-1:0] waddr,
  output logic                  done,
  output logic [DATA_W-1:0]     result,
  output logic                  wreg_q,
  output logic [REG_ADDR_W-1:0] waddr_q
);

  logic [DATA_W-1:0]   shreg;
  logic [SHAMT_W-1:0]  cnt;
  logic [ALU_OP_W-1:0] op_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg   <= '0;
      cnt     <= '0;
      op_q    <= EXE_NOP_OP;
      wreg_q  <= 1'b0;
      waddr_q <= '0;
    end else if (load) begin
      shreg   <= shift1(op, data);
      cnt     <= amt - SHAMT_W'(1);
      op_q    <= op;
      wreg_q  <= wreg;
      waddr_q <= waddr;
    end else if (step) begin
      shreg <= shift1(op_q, shreg);
      cnt   <= cnt - SHAMT_W'(1);
    end
  end

  // Last step is taken combinationally so the result leaves a cycle early
  assign done   = (cnt == SHAMT_W'(1));
  assign result = shift1(op_q, shreg);

endmodule

// File: rtl/ex_stage.sv
// Execute stage: logic unit, shift FSM, EX/MEM register, forward bus.
// EX_FAST_SHIFT_EN selects a 1-cycle barrel shifter with no stalls.
module ex_stage
  import ex_stage_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [ALU_OP_W-1:0]   aluOp,
  input  logic [DATA_W-1:0]     opNum1,
  input  logic [DATA_W-1:0]     opNum2,
  input  logic                  writeReg,
  input  logic [REG_ADDR_W-1:0] writeAddr,
  output logic                  stallreq,
  output logic                  ex_wReg_o,
  output logic [REG_ADDR_W-1:0] ex_wAddr_o,
  output logic [DATA_W-1:0]     ex_wData_o,
  output logic                  mem_wReg,
  output logic [REG_ADDR_W-1:0] mem_wAddr,
  output logic [DATA_W-1:0]     mem_wData
);

  logic [SHAMT_W-1:0] amt;
  logic [DATA_W-1:0]  res;
  logic               res_ok;

  assign amt = opNum1[SHAMT_W-1:0];

  always_comb begin
    res    = ZERO_WORD;
    res_ok = 1'b1;
    case (aluOp)
      EXE_OR_OP:  res = opNum1 | opNum2;
      EXE_AND_OP: res = opNum1 & opNum2;
      EXE_XOR_OP: res = opNum1 ^ opNum2;
      EXE_NOR_OP: res = ~(opNum1 | opNum2);
      EXE_SLL_OP, EXE_SRL_OP, EXE_SRA_OP: begin
`ifdef EX_FAST_SHIFT_EN
        res = shiftn(aluOp, opNum2, amt);
`else
        res = (amt == '0) ? opNum2 : shift1(aluOp, opNum2);
`endif
      end
      default: res_ok = 1'b0;
    endcase
  end

`ifdef EX_FAST_SHIFT_EN

  always_comb begin
    stallreq   = 1'b0;
    ex_wReg_o  = 1'b0;
    ex_wAddr_o = '0;
    ex_wData_o = ZERO_WORD;
    if (rst && in_valid && res_ok) begin
      ex_wReg_o  = writeReg;
      ex_wAddr_o = writeAddr;
      ex_wData_o = res;
    end
  end

`else

  ex_state_e             state;
  ex_state_e             state_nxt;
  logic                  long_shift;
  logic                  sh_load;
  logic                  sh_done;
  logic [DATA_W-1:0]     sh_result;
  logic                  sh_wreg;
  logic [REG_ADDR_W-1:0] sh_waddr;

  assign long_shift = in_valid && is_shift(aluOp) && (amt > SHAMT_W'(1));

  ex_serial_shifter u_shifter (
    .clk     (clk),
    .rst     (rst),
    .load    (sh_load),
    .step    (state == EX_SHIFT),
    .op      (aluOp),
    .data    (opNum2),
    .amt     (amt),
    .wreg    (writeReg),
    .waddr   (writeAddr),
    .done    (sh_done),
    .result  (sh_result),
    .wreg_q  (sh_wreg),
    .waddr_q (sh_waddr)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= EX_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    sh_load    = 1'b0;
    stallreq   = 1'b0;
    ex_wReg_o  = 1'b0;
    ex_wAddr_o = '0;
    ex_wData_o = ZERO_WORD;
    case (state)
      EX_IDLE: begin
        if (long_shift) begin
          stallreq  = 1'b1;
          sh_load   = 1'b1;
          state_nxt = EX_SHIFT;
        end else if (in_valid && res_ok) begin
          ex_wReg_o  = writeReg;
          ex_wAddr_o = writeAddr;
          ex_wData_o = res;
        end
      end
      EX_SHIFT: begin
        if (sh_done) begin
          ex_wReg_o  = sh_wreg;
          ex_wAddr_o = sh_waddr;
          ex_wData_o = sh_result;
          state_nxt  = EX_IDLE;
        end else begin
          stallreq = 1'b1;
        end
      end
      default: state_nxt = EX_IDLE;
    endcase
    // Outputs must read zero while reset is held, even mid-shift
    if (!rst) begin
      sh_load    = 1'b0;
      stallreq   = 1'b0;
      ex_wReg_o  = 1'b0;
      ex_wAddr_o = '0;
      ex_wData_o = ZERO_WORD;
    end
  end

`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_wReg  <= 1'b0;
      mem_wAddr <= '0;
      mem_wData <= ZERO_WORD;
    end else begin
      mem_wReg  <= ex_wReg_o;
      mem_wAddr <= ex_wAddr_o;
      mem_wData <= ex_wData_o;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: logic ops, serial/fast shifts, reset.
// Works in both builds (EX_FAST_SHIFT_EN defined or not).
module tb_ex_stage;
  import ex_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  aluOp;
  logic [31:0] opNum1;
  logic [31:0] opNum2;
  logic        writeReg;
  logic [4:0]  writeAddr;
  logic        stallreq;
  logic        ex_wReg_o;
  logic [4:0]  ex_wAddr_o;
  logic [31:0] ex_wData_o;
  logic        mem_wReg;
  logic [4:0]  mem_wAddr;
  logic [31:0] mem_wData;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ex_stage dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .aluOp      (aluOp),
    .opNum1     (opNum1),
    .opNum2     (opNum2),
    .writeReg   (writeReg),
    .writeAddr  (writeAddr),
    .stallreq   (stallreq),
    .ex_wReg_o  (ex_wReg_o),
    .ex_wAddr_o (ex_wAddr_o),
    .ex_wData_o (ex_wData_o),
    .mem_wReg   (mem_wReg),
    .mem_wAddr  (mem_wAddr),
    .mem_wData  (mem_wData)
  );

`ifdef EX_FAST_SHIFT_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  task automatic issue(input logic [7:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] addr);
    @(negedge clk);
    in_valid  = 1'b1;
    aluOp     = op;
    opNum1    = a;
    opNum2    = b;
    writeReg  = 1'b1;
    writeAddr = addr;
  endtask

  // Counts stall cycles until the result shows; returns with time just before the completing edge
  task automatic wait_result(output int stalls, output logic [31:0] data,
                             output logic ok);
    stalls = 0;
    ok     = 1'b0;
    data   = '0;
    for (int i = 0; i < 64; i++) begin
      #2;
      if (!stallreq) begin
        data = ex_wData_o;
        ok   = 1'b1;
        break;
      end
      stalls++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    in_valid = 1'b1; aluOp = EXE_OR_OP; opNum1 = 32'hFF; opNum2 = 32'h1;
    writeReg = 1'b1; writeAddr = 5'd9;
    #7;
    n_checks++;
    if (ex_wReg_o !== 1'b0 || ex_wData_o !== 32'h0 || ex_wAddr_o !== 5'd0) begin
      n_fail++;
      $display("FAIL reset_comb: wReg=%0b addr=%0d data=%h, required 0/0/0",
               ex_wReg_o, ex_wAddr_o, ex_wData_o);
    end
    n_checks++;
    if (stallreq !== 1'b0 || mem_wReg !== 1'b0 || mem_wAddr !== 5'd0 || mem_wData !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_regs: stall=%0b mem_wReg=%0b addr=%0d data=%h, required all 0",
               stallreq, mem_wReg, mem_wAddr, mem_wData);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
  endtask

  task automatic test_or;
    issue(EXE_OR_OP, 32'h0000FF00, 32'h00F0F0F0, 5'd3);
    #2;
    n_checks++;
    if (ex_wData_o !== 32'h00F0FFF0 || ex_wReg_o !== 1'b1 || ex_wAddr_o !== 5'd3 || stallreq !== 1'b0) begin
      n_fail++;
      $display("FAIL or_comb: data=%h wReg=%0b addr=%0d stall=%0b, required 00f0fff0/1/3/0",
               ex_wData_o, ex_wReg_o, ex_wAddr_o, stallreq);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_checks++;
    if (mem_wData !== 32'h00F0FFF0 || mem_wReg !== 1'b1 || mem_wAddr !== 5'd3) begin
      n_fail++;
      $display("FAIL or_mem: data=%h wReg=%0b addr=%0d, required 00f0fff0/1/3",
               mem_wData, mem_wReg, mem_wAddr);
    end
  endtask

  task automatic test_logic;
    logic [7:0]  ops [4] = '{EXE_AND_OP, EXE_XOR_OP, EXE_NOR_OP, 8'hFF};
    logic [31:0] exp [4] = '{32'h0000F000, 32'h00F00FF0, 32'hFF0F000F, 32'h0};
    for (int i = 0; i < 4; i++) begin
      issue(ops[i], 32'h0000FF00, 32'h00F0F0F0, 5'd12);
      #2;
      n_checks++;
      if (ex_wData_o !== exp[i] || ex_wReg_o !== (i < 3)) begin
        n_fail++;
        $display("FAIL logic_op%0d: data=%h wReg=%0b, required %h/%0b",
                 i, ex_wData_o, ex_wReg_o, exp[i], i < 3);
      end
    end
    issue(EXE_OR_OP, 32'h1, 32'h2, 5'd4);
    in_valid = 1'b0;
    #2;
    n_checks++;
    if (ex_wReg_o !== 1'b0 || ex_wData_o !== 32'h0) begin
      n_fail++;
      $display("FAIL invalid_comb: wReg=%0b data=%h, required 0/0", ex_wReg_o, ex_wData_o);
    end
    @(posedge clk); #1;
    n_checks++;
    if (mem_wReg !== 1'b0) begin
      n_fail++;
      $display("FAIL invalid_mem: mem_wReg=%0b, required 0", mem_wReg);
    end
    issue(EXE_OR_OP, 32'h1, 32'h2, 5'd4);
    writeReg = 1'b0;
    #2;
    n_checks++;
    if (ex_wReg_o !== 1'b0 || ex_wData_o !== 32'h3) begin
      n_fail++;
      $display("FAIL nowrite: wReg=%0b data=%h, required 0/00000003", ex_wReg_o, ex_wData_o);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic test_sra;
    int st; logic [31:0] d; logic ok;
    issue(EXE_SRA_OP, 32'd4, 32'h80000010, 5'd7);
    wait_result(st, d, ok);
    n_checks++;
    if (!ok || d !== 32'hF8000001 || st != (FAST ? 0 : 3)) begin
      n_fail++;
      $display("FAIL sra4: ok=%0b data=%h stalls=%0d, required 1/f8000001/%0d",
               ok, d, st, FAST ? 0 : 3);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_checks++;
    if (mem_wData !== 32'hF8000001 || mem_wReg !== 1'b1 || mem_wAddr !== 5'd7) begin
      n_fail++;
      $display("FAIL sra4_mem: data=%h wReg=%0b addr=%0d, required f8000001/1/7",
               mem_wData, mem_wReg, mem_wAddr);
    end
    issue(EXE_SRA_OP, 32'd2, 32'h80000000, 5'd8);
    wait_result(st, d, ok);
    n_checks++;
    if (!ok || d !== 32'hE0000000 || st != (FAST ? 0 : 1)) begin
      n_fail++;
      $display("FAIL sra2: ok=%0b data=%h stalls=%0d, required 1/e0000000/%0d",
               ok, d, st, FAST ? 0 : 1);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic test_sll_short;
    int st; logic [31:0] d; logic ok;
    issue(EXE_SLL_OP, 32'd0, 32'h40000001, 5'd5);
    wait_result(st, d, ok);
    n_checks++;
    if (!ok || d !== 32'h40000001 || st != 0) begin
      n_fail++;
      $display("FAIL sll0: ok=%0b data=%h stalls=%0d, required 1/40000001/0", ok, d, st);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    issue(EXE_SLL_OP, 32'd1, 32'h40000001, 5'd6);
    wait_result(st, d, ok);
    n_checks++;
    if (!ok || d !== 32'h80000002 || st != 0) begin
      n_fail++;
      $display("FAIL sll1: ok=%0b data=%h stalls=%0d, required 1/80000002/0", ok, d, st);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_checks++;
    if (mem_wData !== 32'h80000002 || mem_wAddr !== 5'd6) begin
      n_fail++;
      $display("FAIL sll1_mem: data=%h addr=%0d, required 80000002/6", mem_wData, mem_wAddr);
    end
  endtask

  task automatic test_srl31;
    int st; logic [31:0] d; logic ok;
    issue(EXE_SRL_OP, 32'hFFFFFFFF, 32'h80000000, 5'd10);
    wait_result(st, d, ok);
    n_checks++;
    if (!ok || d !== 32'h00000001 || st != (FAST ? 0 : 30)) begin
      n_fail++;
      $display("FAIL srl31: ok=%0b data=%h stalls=%0d, required 1/00000001/%0d",
               ok, d, st, FAST ? 0 : 30);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_checks++;
    if (mem_wData !== 32'h00000001 || mem_wReg !== 1'b1 || mem_wAddr !== 5'd10) begin
      n_fail++;
      $display("FAIL srl31_mem: data=%h wReg=%0b addr=%0d, required 00000001/1/10",
               mem_wData, mem_wReg, mem_wAddr);
    end
  endtask

  task automatic test_back_to_back;
    issue(EXE_XOR_OP, 32'hFFFF0000, 32'h0F0F0F0F, 5'd1);
    @(posedge clk); #1;
    aluOp = EXE_SLL_OP; opNum1 = 32'd1; opNum2 = 32'h00000081; writeAddr = 5'd2;
    n_checks++;
    if (mem_wData !== 32'hF0F00F0F || mem_wAddr !== 5'd1) begin
      n_fail++;
      $display("FAIL b2b_first: data=%h addr=%0d, required f0f00f0f/1", mem_wData, mem_wAddr);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_checks++;
    if (mem_wData !== 32'h00000102 || mem_wAddr !== 5'd2 || mem_wReg !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_second: data=%h addr=%0d wReg=%0b, required 00000102/2/1",
               mem_wData, mem_wAddr, mem_wReg);
    end
  endtask

  task automatic test_reset_mid_shift;
    issue(EXE_SLL_OP, 32'd20, 32'h00000001, 5'd11);
    repeat (4) @(posedge clk);
    @(negedge clk); #2;
    if (!FAST) begin
      n_checks++;
      if (stallreq !== 1'b1 || mem_wReg !== 1'b0) begin
        n_fail++;
        $display("FAIL midshift_stall: stall=%0b mem_wReg=%0b, required 1/0", stallreq, mem_wReg);
      end
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (stallreq !== 1'b0 || ex_wReg_o !== 1'b0 || ex_wData_o !== 32'h0 ||
        mem_wReg !== 1'b0 || mem_wData !== 32'h0) begin
      n_fail++;
      $display("FAIL midshift_rst: stall=%0b wReg=%0b data=%h mem_wReg=%0b mem=%h, required all 0",
               stallreq, ex_wReg_o, ex_wData_o, mem_wReg, mem_wData);
    end
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    issue(EXE_OR_OP, 32'h12340000, 32'h00005678, 5'd13);
    #2;
    n_checks++;
    if (stallreq !== 1'b0 || ex_wData_o !== 32'h12345678) begin
      n_fail++;
      $display("FAIL post_rst_or: stall=%0b data=%h, required 0/12345678", stallreq, ex_wData_o);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_checks++;
    if (mem_wData !== 32'h12345678 || mem_wAddr !== 5'd13 || mem_wReg !== 1'b1) begin
      n_fail++;
      $display("FAIL post_rst_mem: data=%h addr=%0d wReg=%0b, required 12345678/13/1",
               mem_wData, mem_wAddr, mem_wReg);
    end
  endtask

  initial begin
    test_reset;
    test_or;
    test_logic;
    test_sra;
    test_sll_short;
    test_srl31;
    test_back_to_back;
    test_reset_mid_shift;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
